sc_dmem_unit: RTL and testbench

Multi-cycle data-memory unit for the MEM step of the multicycle CPU. It accepts one load or store per request, using the address from the ALU-out register and store data from the B register. It runs a configurable wait-state sequence and returns registered, lane-aligned (and optionally sign-extended) read data. That read data feeds the ALU/memory select that loads the data register (DR) ahead of register-file write-back.

---
 rtl/sc_dmem_pkg.sv | 19 +
 rtl/sc_dmem_ram.sv | 30 +++
 rtl/sc_dmem_unit.sv | 141 ++++++++++++++
 tb/tb_sc_dmem_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sc_dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory unit.
package sc_dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int LANE_W     = 8;
   localparam int LANE_IDX_W = 2;
   localparam int CNT_W      = 4;

   // Widen a loaded byte to 32 bits, replicating bit 7 when sx is set.
   function automatic logic [31:0] extend_byte(input logic [LANE_W-1:0] b, input logic sx);
      return {{(32-LANE_W){sx & b[LANE_W-1]}}, b};
   endfunction

endpackage

// File: rtl/sc_dmem_ram.sv
// DEPTH_WORDS x 32 synchronous array with per-byte write enables and a registered read port.
module sc_dmem_ram
   import sc_dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] idx,
   input  logic [3:0]       be,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_reg;

   // Read returns the pre-write contents; the unit never relies on same-edge forwarding.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
         end
      end
      rdata_reg <= mem[idx];
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/sc_dmem_unit.sv
// MEM-step data-memory unit: latches a request, waits WAIT_CYCLES, then performs an aligned word or byte access.
module sc_dmem_unit
   import sc_dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic        byte_en,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        addr_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int AW    = IDX_W + LANE_IDX_W;

   state_t                state_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic [AW-1:0]         addr_reg;
   logic [31:0]           wdata_reg;
   logic                  we_reg;
   logic                  byte_reg;
   logic                  sext_reg;
   logic [31:0]           rdata_reg;
   logic                  ready_reg;
   logic                  busy_reg;
   logic                  addr_err_reg;

   logic [IDX_W-1:0]      ram_idx;
   logic [3:0]            ram_be;
   logic [31:0]           ram_wdata;
   logic [31:0]           ram_q;
   logic [LANE_IDX_W-1:0] lane;
   logic [31:0]           lane_shift;
   logic [31:0]           load_data;
   logic                  access;
   logic                  aligned;
   logic                  unused_addr_hi;

   // Upper address bits only alias onto the same words.
   assign unused_addr_hi = ^addr[31:AW];

   assign lane    = addr_reg[LANE_IDX_W-1:0];
   assign access  = (state_reg == BUSY) && (cnt_reg == '0);
   assign aligned = byte_reg || (lane == '0);

   // In IDLE the read port tracks the incoming address so a zero-wait access still has data ready.
   assign ram_idx = (state_reg == IDLE) ? addr[AW-1:LANE_IDX_W] : addr_reg[AW-1:LANE_IDX_W];

   assign ram_wdata = byte_reg ? {4{wdata_reg[LANE_W-1:0]}} : wdata_reg;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_be
         assign ram_be[gi] = access && we_reg && aligned &&
                             (!byte_reg || (lane == LANE_IDX_W'(gi)));
      end
   endgenerate

   assign lane_shift = ram_q >> {lane, 3'b000};
   assign load_data  = byte_reg ? extend_byte(lane_shift[LANE_W-1:0], sext_reg) : ram_q;

   sc_dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_ram (
      .clk   (clk),
      .idx   (ram_idx),
      .be    (ram_be),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         we_reg       <= 1'b0;
         byte_reg     <= 1'b0;
         sext_reg     <= 1'b0;
         rdata_reg    <= '0;
         ready_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         addr_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req) begin
                  addr_reg  <= addr[AW-1:0];
                  wdata_reg <= wdata;
                  we_reg    <= we;
                  byte_reg  <= byte_en;
                  sext_reg  <= sign_ext;
                  cnt_reg   <= CNT_W'(WAIT_CYCLES);
                  busy_reg  <= 1'b1;
                  state_reg <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_reg == '0) begin
                  if (!we_reg && aligned) begin
                     rdata_reg <= load_data;
                  end
                  addr_err_reg <= !aligned;
                  busy_reg     <= 1'b0;
                  ready_reg    <= 1'b1;
                  state_reg    <= DONE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            DONE: begin
               ready_reg    <= 1'b0;
               addr_err_reg <= 1'b0;
               state_reg    <= IDLE;
            end
            default: begin
               ready_reg    <= 1'b0;
               busy_reg     <= 1'b0;
               addr_err_reg <= 1'b0;
               state_reg    <= IDLE;
            end
         endcase
      end
   end

   assign rdata    = rdata_reg;
   assign ready    = ready_reg;
   assign busy     = busy_reg;
   assign addr_err = addr_err_reg;

endmodule

// File: tb/tb_sc_dmem_unit.sv
// Directed bench for sc_dmem_unit with default parameters (64 words, 2 wait states).
module tb_sc_dmem_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        we;
   logic        byte_en;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        busy;
   logic        addr_err;

   int checks   = 0;
   int failures = 0;

   logic [31:0] got_rdata;
   logic        got_err;
   int          got_lat;
   int          got_busy;
   logic        got_ready;

   always #5 clk = ~clk;

   sc_dmem_unit #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .byte_en  (byte_en),
      .sign_ext (sign_ext),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .busy     (busy),
      .addr_err (addr_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // One request; hold keeps req asserted through BUSY to test that it is ignored.
   task automatic access(input logic w, input logic b, input logic sx,
                         input logic [31:0] a, input logic [31:0] d, input logic hold);
      @(negedge clk);
      req = 1'b1; we = w; byte_en = b; sign_ext = sx; addr = a; wdata = d;
      @(posedge clk);
      got_lat = 0; got_busy = 0; got_ready = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (!hold) req = 1'b0;
         addr = 32'hFFFF_FFFF; wdata = 32'h0;
         if (busy) got_busy++;
         if (ready) begin
            got_lat = n - 1; got_ready = 1'b1;
            got_rdata = rdata; got_err = addr_err;
            check("ready_busy_exclusive", {31'b0, busy}, 32'd0);
            break;
         end
      end
      req = 1'b0;
      check("ready_seen", {31'b0, got_ready}, 32'd1);
      check("latency", got_lat, 32'd3);
      check("busy_cycles", got_busy, 32'd3);
      $display("txn we=%0b byte=%0b sx=%0b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b lat=%0d",
               w, b, sx, a, d, got_rdata, got_err, got_lat);
      @(negedge clk);
      check("ready_one_cycle", {31'b0, ready}, 32'd0);
      check("err_outside_done", {31'b0, addr_err}, 32'd0);
   endtask

   task automatic idle_watch(input string tag, input int cycles);
      int seen = 0;
      for (int n = 0; n < cycles; n++) begin
         @(negedge clk);
         if (ready || busy) seen++;
      end
      check(tag, seen, 32'd0);
   endtask

   initial begin
      rst_n = 1'b1; req = 1'b0; we = 1'b0; byte_en = 1'b0; sign_ext = 1'b0;
      addr = '0; wdata = '0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst_rdata", rdata, 32'd0);
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_err", {31'b0, addr_err}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      idle_watch("idle_no_ready", 10);

      // Word store then load
      access(1, 0, 0, 32'h10, 32'hDEADBEEF, 0);
      check("sw_err", {31'b0, got_err}, 32'd0);
      check("sw_rdata_unchanged", got_rdata, 32'd0);
      access(0, 0, 0, 32'h10, 32'h0, 0);
      check("lw_10", got_rdata, 32'hDEADBEEF);

      // Byte lanes
      access(1, 0, 0, 32'h10, 32'h11223344, 0);
      check("sw_keeps_rdata", got_rdata, 32'hDEADBEEF);
      access(1, 1, 0, 32'h13, 32'hAAAAAA80, 0);
      access(0, 0, 0, 32'h10, 32'h0, 0);
      check("lw_after_sb", got_rdata, 32'h80223344);
      access(0, 1, 1, 32'h13, 32'h0, 0);
      check("lb_sx1", got_rdata, 32'hFFFFFF80);
      access(0, 1, 0, 32'h13, 32'h0, 0);
      check("lb_sx0", got_rdata, 32'h00000080);
      access(0, 1, 1, 32'h10, 32'h0, 0);
      check("lb_lane0", got_rdata, 32'h00000044);
      access(0, 1, 1, 32'h12, 32'h0, 0);
      check("lb_lane2", got_rdata, 32'h00000022);

      // Misaligned word accesses
      access(1, 0, 0, 32'h04, 32'h0BADF00D, 0);
      access(0, 0, 0, 32'h04, 32'h0, 0);
      check("lw_04", got_rdata, 32'h0BADF00D);
      access(0, 0, 0, 32'h06, 32'h0, 0);
      check("lw_mis_err", {31'b0, got_err}, 32'd1);
      check("lw_mis_rdata", got_rdata, 32'h0BADF00D);
      access(0, 1, 0, 32'h10, 32'h0, 0);
      access(1, 0, 0, 32'h06, 32'hFFFFFFFF, 0);
      check("sw_mis_err", {31'b0, got_err}, 32'd1);
      check("sw_mis_rdata", got_rdata, 32'h00000044);
      access(0, 0, 0, 32'h04, 32'h0, 0);
      check("word1_intact", got_rdata, 32'h0BADF00D);
      check("aligned_err", {31'b0, got_err}, 32'd0);

      // Address wrap and held req
      access(1, 0, 0, 32'h104, 32'h5A5A5A5A, 1);
      idle_watch("held_req_no_second", 6);
      access(0, 0, 0, 32'h004, 32'h0, 0);
      check("lw_wrap", got_rdata, 32'h5A5A5A5A);

      // Reset during a pending store
      access(1, 0, 0, 32'h20, 32'hCAFEF00D, 0);
      access(0, 0, 0, 32'h20, 32'h0, 0);
      check("lw_20_pre", got_rdata, 32'hCAFEF00D);
      @(negedge clk);
      req = 1'b1; we = 1'b1; byte_en = 1'b0; addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk); req = 1'b0;
      check("abort_busy_before", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_rdata", rdata, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_ready", {31'b0, ready}, 32'd0);
      $display("txn reset during sw addr=0x00000020 wdata=0x12345678");
      @(negedge clk); rst_n = 1'b1;
      idle_watch("abort_no_ready", 6);
      access(0, 0, 0, 32'h20, 32'h0, 0);
      check("lw_20_post", got_rdata, 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
